lcd_bus_arbiter: RTL and testbench



---
 rtl/lcd_bus_arbiter_pkg.sv | 29 ++
 rtl/lcd_bus_arbiter_if.sv | 26 ++
 rtl/lcd_bus_arbiter_rr_grant.sv | 19 +
 rtl/lcd_bus_arbiter.sv | 114 +++++++++++
 tb/tb_lcd_bus_arbiter.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/lcd_bus_arbiter_pkg.sv
// lcd_pkg: shared types, default timing and command codes for the
// character-LCD bus arbiter.
//   lcd_state_e  - arbiter FSM state encoding
//   DEF_T_*      - default cycle counts for setup / EN pulse / post-write waits
//   LCD_CMD_*    - HD44780 command codes that need the long execution wait
//   is_slow_cmd  - 1 when a byte is clear or return-home (0x01..0x03, rs=0)
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } lcd_state_e;

  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_EN    = 16;
  localparam int DEF_T_CMD   = 2500;
  localparam int DEF_T_SLOW  = 90000;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Return-home ignores bit 0, so 0x02 and 0x03 are both slow.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data[7:1] == LCD_CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// lcd_bus_arbiter_if: requester handshakes plus LCD pin bundle.
//   req{0,1}_valid/rs/data : requester -> arbiter byte offer
//   req{0,1}_ready/done    : arbiter -> requester accept / completion pulse
//   busy, LCD_DATA/RS/EN/RW: arbiter status and LCD pins
// modport master = requester/pin side, modport slave = arbiter side.
interface lcd_bus_arbiter_if;
  logic       req0_valid, req0_rs, req0_ready, req0_done;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_ready, req1_done;
  logic [7:0] req1_data;
  logic       busy;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_EN, LCD_RW;

  modport master (
    output req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    input  req0_ready, req0_done, req1_ready, req1_done,
    input  busy, LCD_DATA, LCD_RS, LCD_EN, LCD_RW
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    output req0_ready, req0_done, req1_ready, req1_done,
    output busy, LCD_DATA, LCD_RS, LCD_EN, LCD_RW
  );
endinterface

// File: rtl/lcd_bus_arbiter_rr_grant.sv
// lcd_rr_grant: two-way grant selection.
//   i_valid      - requester valids [1:0]
//   i_last_grant - index granted last time
//   o_grant      - index to grant now
// Build option: LCD_ARB_FIXED_PRIO_EN makes requester 0 win every tie.
module lcd_rr_grant (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_grant
);
`ifdef LCD_ARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = i_last_grant;
  assign o_grant       = i_valid[1] & ~i_valid[0];
`else
  // Tie (or nobody asking): alternate away from the previous owner.
  assign o_grant = (i_valid[0] == i_valid[1]) ? ~i_last_grant : i_valid[1];
`endif
endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares one HD44780 bus between two byte requesters.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - lcd_bus_arbiter_if.slave (handshakes, busy, LCD pins)
// Per accepted byte: T_SETUP cycles of data/RS setup, T_EN cycles EN high,
// then T_CMD (or T_SLOW for clear/home) cycles of execution wait; the owner
// gets a done pulse on the last wait cycle.
// Build option: LCD_ARB_FIXED_PRIO_EN (see lcd_rr_grant).
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_EN    = DEF_T_EN,
  parameter int T_CMD   = DEF_T_CMD,
  parameter int T_SLOW  = DEF_T_SLOW
) (
  input logic             clk,
  input logic             rst,
  lcd_bus_arbiter_if.slave bus
);
  localparam int T_MAX0 = (T_SLOW > T_CMD) ? T_SLOW : T_CMD;
  localparam int T_MAX1 = (T_EN > T_SETUP) ? T_EN : T_SETUP;
  localparam int T_MAX  = (T_MAX0 > T_MAX1) ? T_MAX0 : T_MAX1;
  localparam int TW     = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] L_SETUP = TW'(T_SETUP);
  localparam logic [TW-1:0] L_EN    = TW'(T_EN);
  localparam logic [TW-1:0] L_CMD   = TW'(T_CMD);
  localparam logic [TW-1:0] L_SLOW  = TW'(T_SLOW);
  localparam logic [TW-1:0] L_ONE   = TW'(1);
  localparam logic [TW-1:0] L_TWO   = TW'(2);

  lcd_state_e    r_state;
  logic [TW-1:0] r_timer;
  logic          r_last_grant, r_owner;
  logic [7:0]    r_data;
  logic          r_rs, r_en, r_done0, r_done1;
  logic          w_grant, w_idle, w_acc;
  logic [TW-1:0] w_tw;

  lcd_rr_grant u_grant (
    .i_valid      ({bus.req1_valid, bus.req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_idle         = (r_state == ST_IDLE);
  assign w_acc          = w_idle && (w_grant ? bus.req1_valid : bus.req0_valid);
  // Latched byte lives in the LCD output registers, so Tw derives from them.
  assign w_tw           = is_slow_cmd(r_rs, r_data) ? L_SLOW : L_CMD;

  assign bus.req0_ready = w_idle && !w_grant;
  assign bus.req1_ready = w_idle &&  w_grant;
  assign bus.req0_done  = r_done0;
  assign bus.req1_done  = r_done1;
  assign bus.busy       = !w_idle;
  assign bus.LCD_DATA   = r_data;
  assign bus.LCD_RS     = r_rs;
  assign bus.LCD_EN     = r_en;
  assign bus.LCD_RW     = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_data       <= 8'h00;
      r_rs         <= 1'b0;
      r_en         <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      unique case (r_state)
        ST_IDLE: if (w_acc) begin
          r_owner      <= w_grant;
          r_last_grant <= w_grant;
          r_data       <= w_grant ? bus.req1_data : bus.req0_data;
          r_rs         <= w_grant ? bus.req1_rs   : bus.req0_rs;
          r_timer      <= L_SETUP;
          r_state      <= ST_SETUP;
        end
        ST_SETUP: if (r_timer == L_ONE) begin
          r_en    <= 1'b1;
          r_timer <= L_EN;
          r_state <= ST_PULSE;
        end else r_timer <= r_timer - L_ONE;
        ST_PULSE: if (r_timer == L_ONE) begin
          r_en    <= 1'b0;
          r_timer <= w_tw;
          r_state <= ST_HOLD;
          // One-cycle hold: the first HOLD cycle is already the last.
          if (w_tw == L_ONE) begin
            r_done0 <= !r_owner;
            r_done1 <=  r_owner;
          end
        end else r_timer <= r_timer - L_ONE;
        ST_HOLD: begin
          // Done is registered, so raise it one count early.
          if (r_timer == L_TWO) begin
            r_done0 <= !r_owner;
            r_done1 <=  r_owner;
          end
          if (r_timer == L_ONE) begin
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else r_timer <= r_timer - L_ONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
module tb_lcd_bus_arbiter;
  localparam int S = 2, E = 4, TC = 10, TS = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcd_bus_arbiter_if bus();

  lcd_bus_arbiter #(.T_SETUP(S), .T_EN(E), .T_CMD(TC), .T_SLOW(TS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus variables
  logic       v0 = 0, rs0 = 0, v1 = 0, rs1 = 0, rst_i = 1, drop = 1, chk_on = 0;
  logic [7:0] d0 = 0, d1 = 0;

  // Reference model: a transaction is (accept cycle, owner, byte, wait length);
  // every output is a function of the cycle offset from the accept.
  int         cyc_n = 0, n_vec = 0, n_err = 0, lat = -1;
  logic       m_active = 0, m_owner = 0, m_last = 1, m_lrs = 0;
  int         m_a = 0, m_tw = TC;
  logic [7:0] m_ld = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic logic grant_of(input logic a0, input logic a1, input logic last);
`ifdef LCD_ARB_FIXED_PRIO_EN
    return a1 && !a0;
`else
    if (a0 && a1) return !last;
    return a1;
`endif
  endfunction

  task automatic cyc();
    int k, tot;
    logic g, acc0, acc1;
    @(negedge clk);
    rst = rst_i;
    bus.req0_valid = v0; bus.req0_rs = rs0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_rs = rs1; bus.req1_data = d1;
    #1;
    tot = S + E + m_tw;
    if (m_active && cyc_n > m_a + tot) m_active = 0;
    k = cyc_n - m_a;
    g = grant_of(v0, v1, m_last);
    if (chk_on) begin
      chk("busy",   16'(bus.busy),      16'(m_active));
      chk("en",     16'(bus.LCD_EN),    16'(m_active && k > S && k <= S + E));
      chk("data",   16'(bus.LCD_DATA),  16'(m_ld));
      chk("rs",     16'(bus.LCD_RS),    16'(m_lrs));
      chk("rw",     16'(bus.LCD_RW),    16'(0));
      chk("done0",  16'(bus.req0_done), 16'(m_active && !m_owner && k == tot));
      chk("done1",  16'(bus.req1_done), 16'(m_active &&  m_owner && k == tot));
      if (v0) chk("ready0", 16'(bus.req0_ready), 16'(!m_active && !g));
      if (v1) chk("ready1", 16'(bus.req1_ready), 16'(!m_active &&  g));
    end
    acc0 = !m_active && v0 && !g;
    acc1 = !m_active && v1 &&  g;
    if (m_active && k == tot) lat = k;
    @(posedge clk);
    if (rst_i) begin
      m_active = 0; m_last = 1; m_ld = 0; m_lrs = 0; m_owner = 0;
    end else if (acc0 || acc1) begin
      m_active = 1; m_a = cyc_n; m_owner = acc1; m_last = acc1;
      m_ld  = acc1 ? d1 : d0;
      m_lrs = acc1 ? rs1 : rs0;
      m_tw  = (!m_lrs && m_ld >= 1 && m_ld <= 3) ? TS : TC;
    end
    cyc_n++;
    if (drop && !rst_i) begin
      if (acc0) v0 = 0;
      if (acc1) v1 = 0;
    end
  endtask

  initial begin
    // Reset: first edge makes state known, second cycle checks reset values
    cyc();
    chk_on = 1;
    cyc();
    rst_i = 0;

    // Single character from req0
    v0 = 1; rs0 = 1; d0 = 8'h41; lat = -1;
    repeat (18) cyc();
    chk("lat_char", 16'(lat), 16'd16);

    // Clear command (slow) then function set (normal) from req1
    v1 = 1; rs1 = 0; d1 = 8'h01; lat = -1;
    repeat (48) cyc();
    chk("lat_clear", 16'(lat), 16'd46);
    v1 = 1; rs1 = 0; d1 = 8'h38; lat = -1;
    repeat (18) cyc();
    chk("lat_cmd", 16'(lat), 16'd16);

    // Both held valid: alternating grants, each owner's byte on the bus
    drop = 0;
    v0 = 1; rs0 = 1; d0 = 8'h55;
    v1 = 1; rs1 = 1; d1 = 8'h66;
    repeat (4 * 17 + 2) cyc();
    v0 = 0; v1 = 0;
    repeat (20) cyc();

    // Reset during PULSE (cycle 4), request still valid afterwards
    v0 = 1; rs0 = 1; d0 = 8'h41;
    repeat (4) cyc();
    rst_i = 1; cyc();
    rst_i = 0; cyc();
    v0 = 0; lat = -1;
    repeat (17) cyc();
    chk("lat_after_rst", 16'(lat), 16'd16);

    // Data changes after accept must not reach the bus
    v0 = 1; rs0 = 1; d0 = 8'h41;
    cyc();
    d0 = 8'h42;
    cyc();
    v0 = 0;
    repeat (18) cyc();

    // Random traffic, occasional reset
    drop = 1;
    repeat (800) begin
      if (!v0 && $urandom_range(3) == 0) begin
        v0 = 1; rs0 = 1'($urandom);
        d0 = $urandom_range(1) ? 8'($urandom_range(3)) : 8'($urandom);
      end
      if (!v1 && $urandom_range(3) == 0) begin
        v1 = 1; rs1 = 1'($urandom);
        d1 = $urandom_range(1) ? 8'($urandom_range(3)) : 8'($urandom);
      end
      rst_i = ($urandom_range(199) == 0);
      cyc();
    end
    rst_i = 0; v0 = 0; v1 = 0;
    repeat (60) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
